// File: rtl/page_transfer_controller.sv
// Page transfer controller: round-robin arbitration of per-core page-out/page-in
// requests, sequencing 16 rows of 256 bits between core local memory and main memory.
module page_transfer_controller #(
  parameter int NUM_CORES = 2,
  parameter int CORE_ID_W = 1
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [NUM_CORES-1:0]      out_ready,
  input  logic [8*NUM_CORES-1:0]    out_local_page,
  input  logic [32*NUM_CORES-1:0]   out_main_page,
  output logic [NUM_CORES-1:0]      out_accepted,
  input  logic [NUM_CORES-1:0]      in_request,
  input  logic [8*NUM_CORES-1:0]    in_local_page,
  input  logic [32*NUM_CORES-1:0]   in_main_page,
  output logic [NUM_CORES-1:0]      in_done,
  output logic [7:0]                core_local_page,
  output logic [3:0]                core_offset,
  output logic [255:0]              core_data,
  output logic [NUM_CORES-1:0]      core_write_page_in,
  input  logic [256*NUM_CORES-1:0]  core_row_data,
  output logic                      mem_req,
  output logic                      mem_we,
  output logic [35:0]               mem_addr,
  output logic [255:0]              mem_wdata,
  input  logic [255:0]              mem_rdata,
  input  logic                      mem_ack,
  output logic                      busy,
  output logic [CORE_ID_W-1:0]      grant_id
);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] OUT_ADDR = 3'd1;
  localparam logic [2:0] OUT_MEM  = 3'd2;
  localparam logic [2:0] IN_MEM   = 3'd3;
  localparam logic [2:0] IN_WRITE = 3'd4;
  localparam logic [2:0] DONE     = 3'd5;

  logic [2:0]           state;
  logic [CORE_ID_W-1:0] rr_ptr;
  logic [CORE_ID_W-1:0] id_q;
  logic                 dir_out_q;
  logic [7:0]           local_page_q;
  logic [31:0]          main_page_q;
  logic [3:0]           offset_q;
  logic [255:0]         rdata_q;
  logic [255:0]         wdata_q;
  logic                 wdata_held;

  logic [2*NUM_CORES-1:0] req_dbl, out_dbl;
  logic [NUM_CORES-1:0]   req_rot, out_rot;
  logic [CORE_ID_W:0]     id_sum;
  logic                   arb_found, arb_out;
  logic [CORE_ID_W-1:0]   arb_id;

  // Rotate the request vector so bit 0 is the core at the round-robin pointer.
  // NOTE: every variable driven here gets a default first, so no latch can be inferred.
  always_comb begin
    req_dbl   = {out_ready | in_request, out_ready | in_request};
    out_dbl   = {out_ready, out_ready};
    req_rot   = NUM_CORES'(req_dbl >> rr_ptr);
    out_rot   = NUM_CORES'(out_dbl >> rr_ptr);
    arb_found = 1'b0;
    arb_out   = 1'b0;
    arb_id    = '0;
    id_sum    = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      if (!arb_found && req_rot[i]) begin
        arb_found = 1'b1;
        arb_out   = out_rot[i];
        id_sum    = {1'b0, rr_ptr} + (CORE_ID_W+1)'(i);
        if (id_sum >= (CORE_ID_W+1)'(NUM_CORES))
          id_sum = id_sum - (CORE_ID_W+1)'(NUM_CORES);
        arb_id = id_sum[CORE_ID_W-1:0];
      end
    end
  end

  logic [7:0]   sel_local_page;
  logic [31:0]  sel_main_page;
  logic [255:0] row_sel;

  always_comb begin
    sel_local_page     = '0;
    sel_main_page      = '0;
    row_sel            = '0;
    core_write_page_in = '0;
    out_accepted       = '0;
    in_done            = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      if (arb_id == CORE_ID_W'(i)) begin
        sel_local_page = arb_out ? out_local_page[8*i +: 8]  : in_local_page[8*i +: 8];
        sel_main_page  = arb_out ? out_main_page[32*i +: 32] : in_main_page[32*i +: 32];
      end
      if (id_q == CORE_ID_W'(i)) begin
        row_sel               = core_row_data[256*i +: 256];
        core_write_page_in[i] = (state == IN_WRITE);
        out_accepted[i]       = (state == DONE) && dir_out_q;
        in_done[i]            = (state == DONE) && !dir_out_q;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples the pre-edge values of its neighbours.
  // NOTE: the wide data registers are reset as well because every output must read zero in reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      rr_ptr       <= '0;
      id_q         <= '0;
      dir_out_q    <= 1'b0;
      local_page_q <= '0;
      main_page_q  <= '0;
      offset_q     <= '0;
      rdata_q      <= '0;
      wdata_q      <= '0;
      wdata_held   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (arb_found) begin
          id_q         <= arb_id;
          dir_out_q    <= arb_out;
          local_page_q <= sel_local_page;
          main_page_q  <= sel_main_page;
          offset_q     <= '0;
          state        <= arb_out ? OUT_ADDR : IN_MEM;
        end
        OUT_ADDR: begin
          wdata_held <= 1'b0;
          state      <= OUT_MEM;
        end
        OUT_MEM: begin
          // Row data arrives in the first OUT_MEM cycle; freeze it for any ack wait.
          if (!wdata_held) begin
            wdata_q    <= row_sel;
            wdata_held <= 1'b1;
          end
          if (mem_ack) begin
            if (offset_q == 4'd15) state <= DONE;
            else begin
              offset_q <= offset_q + 4'd1;
              state    <= OUT_ADDR;
            end
          end
        end
        IN_MEM: if (mem_ack) begin
          rdata_q <= mem_rdata;
          state   <= IN_WRITE;
        end
        IN_WRITE: begin
          if (offset_q == 4'd15) state <= DONE;
          else begin
            offset_q <= offset_q + 4'd1;
            state    <= IN_MEM;
          end
        end
        DONE: begin
          rr_ptr <= (id_q == CORE_ID_W'(NUM_CORES-1)) ? '0 : id_q + CORE_ID_W'(1);
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy            = (state != IDLE);
  assign grant_id        = id_q;
  assign core_local_page = local_page_q;
  assign core_offset     = offset_q;
  assign core_data       = rdata_q;
  assign mem_req         = (state == OUT_MEM) || (state == IN_MEM);
  assign mem_we          = (state == OUT_MEM);
  assign mem_addr        = {main_page_q, offset_q};
  assign mem_wdata       = (state == OUT_MEM) ? (wdata_held ? wdata_q : row_sel) : '0;

endmodule

// File: tb/tb_page_transfer_controller.sv
// Self-checking bench for page_transfer_controller: directed table, multi-cycle corner
// sequences and randomized request rounds scored against a transaction-level model.
module tb_page_transfer_controller;
  localparam int N   = 2;
  localparam int IDW = 1;

  logic               clock = 1'b0;
  logic               reset;
  logic [N-1:0]       out_ready, in_request, out_accepted, in_done, core_write_page_in;
  logic [8*N-1:0]     out_local_page, in_local_page;
  logic [32*N-1:0]    out_main_page, in_main_page;
  logic [7:0]         core_local_page;
  logic [3:0]         core_offset;
  logic [255:0]       core_data;
  logic [256*N-1:0]   core_row_data;
  logic               mem_req, mem_we, mem_ack;
  logic [35:0]        mem_addr;
  logic [255:0]       mem_wdata, mem_rdata;
  logic               busy;
  logic [IDW-1:0]     grant_id;

  page_transfer_controller #(.NUM_CORES(N), .CORE_ID_W(IDW)) dut (
    .clock(clock), .reset(reset),
    .out_ready(out_ready), .out_local_page(out_local_page), .out_main_page(out_main_page),
    .out_accepted(out_accepted),
    .in_request(in_request), .in_local_page(in_local_page), .in_main_page(in_main_page),
    .in_done(in_done),
    .core_local_page(core_local_page), .core_offset(core_offset), .core_data(core_data),
    .core_write_page_in(core_write_page_in), .core_row_data(core_row_data),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .busy(busy), .grant_id(grant_id)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic         we;
    logic [35:0]  addr;
    logic [255:0] data;
  } mem_txn_t;

  typedef struct packed {
    logic [N-1:0] mask;
    logic [7:0]   page;
    logic [3:0]   off;
    logic [255:0] data;
  } row_wr_t;

  typedef struct {
    int          core;
    bit          is_out;
    logic [7:0]  lp;
    logic [31:0] mp;
    int          wait_c;
    logic [35:0] first_addr;
    logic [35:0] last_addr;
    int          latency;
  } vec_t;

  mem_txn_t    mem_q[$];
  row_wr_t     wr_q[$];
  int          n_checks = 0;
  int          n_pass   = 0;
  int          wait_cfg = 0;
  int          wait_cnt;
  int          model_rr = 0;
  logic [35:0] act_first, act_last;

  function automatic logic [255:0] row_value(int c, logic [7:0] page, logic [3:0] off);
    return {32'(c), 212'd0, page, off};
  endfunction

  function automatic logic [255:0] mem_value(logic [35:0] a);
    return {a, ~a, a, ~a, a, ~a, a, 4'hA};
  endfunction

  task automatic check(input string name, input logic [299:0] act, input logic [299:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic finish_sim();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  endtask

  // Core local memories answer a row read one cycle after the address is presented.
  always @(posedge clock)
    for (int c = 0; c < N; c++)
      core_row_data[256*c +: 256] <= row_value(c, core_local_page, core_offset);

  // Main memory: acknowledges after wait_cfg wait cycles.
  always @(posedge clock or posedge reset)
    if (reset) wait_cnt <= 0;
    else if (mem_req && !mem_ack) wait_cnt <= wait_cnt + 1;
    else wait_cnt <= 0;

  assign mem_ack   = mem_req && (wait_cnt >= wait_cfg);
  assign mem_rdata = mem_value(mem_addr);

  logic     prev_pend;
  mem_txn_t prev_txn;

  always @(negedge clock) begin
    if (reset) prev_pend <= 1'b0;
    else begin
      if (prev_pend)
        check("mem_hold", 300'({mem_req, mem_we, mem_addr, mem_wdata}),
              300'({1'b1, prev_txn.we, prev_txn.addr, prev_txn.data}));
      check("wr_onehot", 300'($onehot0(core_write_page_in)), 300'(1));
      check("req_vs_wr", 300'(mem_req && (|core_write_page_in)), 300'(0));
      check("req_outside_xfer", 300'(mem_req && !(busy && !(|{out_accepted, in_done}))), 300'(0));
      if (mem_req && mem_ack) mem_q.push_back({mem_we, mem_addr, mem_we ? mem_wdata : mem_rdata});
      if (|core_write_page_in) wr_q.push_back({core_write_page_in, core_local_page, core_offset, core_data});
      prev_pend <= mem_req && !mem_ack;
      prev_txn  <= {mem_we, mem_addr, mem_wdata};
    end
  end

  // Reference arbitration: scan from the pointer, page-out before page-in.
  function automatic void model_pick(output int c, output bit is_out);
    c = -1;
    is_out = 1'b0;
    for (int i = 0; i < N; i++) begin
      int idx;
      idx = (model_rr + i) % N;
      if (c < 0 && (out_ready[idx] || in_request[idx])) begin
        c = idx;
        is_out = out_ready[idx];
      end
    end
  endfunction

  task automatic run_transfer(input int cyc0, input bit hold, input bit drop_at4,
                              output int granted, output int latency);
    int          c;
    bit          is_out, seen, dropped;
    logic [7:0]  lp;
    logic [31:0] mp;
    int          cyc;
    mem_txn_t    m;
    row_wr_t     w;
    model_pick(c, is_out);
    granted = c;
    latency = 0;
    if (c < 0) return;
    lp = is_out ? out_local_page[8*c +: 8]  : in_local_page[8*c +: 8];
    mp = is_out ? out_main_page[32*c +: 32] : in_main_page[32*c +: 32];
    cyc = cyc0;
    seen = 0;
    dropped = 0;
    while (!seen) begin
      @(negedge clock);
      cyc++;
      if (cyc == 2) check("grant", 300'({busy, grant_id}), 300'({1'b1, IDW'(c)}));
      if (drop_at4 && !dropped && busy && core_offset == 4'd4) begin
        out_ready[c] = 1'b0;
        in_request[c] = 1'b0;
        out_local_page[8*c +: 8]  = 8'hEE;
        out_main_page[32*c +: 32] = 32'hDEADBEEF;
        dropped = 1;
      end
      if (|{out_accepted, in_done}) seen = 1;
      else if (cyc > 2000) begin
        $display("FAIL done_timeout: no completion pulse after %0d cycles", cyc);
        n_checks++;
        finish_sim();
      end
    end
    latency = cyc;
    check("done_pulse", 300'({out_accepted, in_done}),
          300'({is_out ? N'(1 << c) : N'(0), is_out ? N'(0) : N'(1 << c)}));
    check("mem_row_count", 300'(mem_q.size()), 300'(16));
    check("core_wr_count", 300'(wr_q.size()), 300'(is_out ? 0 : 16));
    for (int k = 0; k < 16; k++) begin
      if (mem_q.size() > 0) begin
        m = mem_q.pop_front();
        if (k == 0) act_first = m.addr;
        if (k == 15) act_last = m.addr;
        check("mem_row", 300'(m), 300'({is_out, mp, 4'(k),
              is_out ? row_value(c, lp, 4'(k)) : mem_value({mp, 4'(k)})}));
      end
      if (!is_out && wr_q.size() > 0) begin
        w = wr_q.pop_front();
        check("core_row", 300'(w), 300'({N'(1 << c), lp, 4'(k), mem_value({mp, 4'(k)})}));
      end
    end
    mem_q.delete();
    wr_q.delete();
    model_rr = (c + 1) % N;
    if (!hold) begin
      if (is_out) out_ready[c] = 1'b0;
      else in_request[c] = 1'b0;
    end
  endtask

  task automatic set_req(input int c, input bit is_out, input logic [7:0] lp, input logic [31:0] mp);
    if (is_out) begin
      out_local_page[8*c +: 8]  = lp;
      out_main_page[32*c +: 32] = mp;
      out_ready[c] = 1'b1;
    end else begin
      in_local_page[8*c +: 8]  = lp;
      in_main_page[32*c +: 32] = mp;
      in_request[c] = 1'b1;
    end
  endtask

  vec_t vecs[4];

  initial begin
    int g, lat, prev_g, total, cyc;
    vecs[0] = '{0, 1'b1, 8'h03, 32'h10,       0, 36'h100,       36'h10F,       34};
    vecs[1] = '{1, 1'b0, 8'h05, 32'h2,        3, 36'h020,       36'h02F,       82};
    vecs[2] = '{1, 1'b1, 8'hFF, 32'hFFFFFFFF, 1, 36'hFFFFFFFF0, 36'hFFFFFFFFF, 50};
    vecs[3] = '{0, 1'b0, 8'h00, 32'h0,        0, 36'h000,       36'h00F,       34};

    reset = 1'b1;
    out_ready = '0; in_request = '0;
    out_local_page = '0; in_local_page = '0;
    out_main_page = '0; in_main_page = '0;
    repeat (3) @(negedge clock);
    check("reset_mem",  300'({mem_req, mem_we, mem_addr, mem_wdata}), 300'(0));
    check("reset_core", 300'({core_local_page, core_offset, core_data, core_write_page_in}), 300'(0));
    check("reset_ctrl", 300'({busy, grant_id, out_accepted, in_done}), 300'(0));
    reset = 1'b0;
    repeat (3) @(negedge clock);
    check("idle_no_req", 300'({busy, mem_req}), 300'(0));

    foreach (vecs[i]) begin
      @(negedge clock);
      wait_cfg = vecs[i].wait_c;
      set_req(vecs[i].core, vecs[i].is_out, vecs[i].lp, vecs[i].mp);
      run_transfer(1, 0, 0, g, lat);
      check("tbl_first_addr", 300'(act_first), 300'(vecs[i].first_addr));
      check("tbl_last_addr",  300'(act_last),  300'(vecs[i].last_addr));
      check("tbl_latency",    300'(lat),       300'(vecs[i].latency));
    end

    // Page-out and page-in raised together on one core.
    @(negedge clock);
    wait_cfg = 0;
    set_req(0, 1'b1, 8'h07, 32'h70);
    set_req(0, 1'b0, 8'h08, 32'h80);
    run_transfer(1, 0, 0, g, lat);
    run_transfer(0, 0, 0, g, lat);

    // Both cores hold page-out continuously: grants must alternate.
    @(negedge clock);
    set_req(0, 1'b1, 8'h11, 32'h40);
    set_req(1, 1'b1, 8'h22, 32'h50);
    prev_g = -1;
    for (int k = 0; k < 4; k++) begin
      run_transfer(k == 0 ? 1 : 0, 1, 0, g, lat);
      if (k > 0) check("rr_alternate", 300'(g == prev_g), 300'(0));
      prev_g = g;
    end
    out_ready = '0;

    // Request withdrawn and pages changed at row 4.
    @(negedge clock);
    wait_cfg = 1;
    set_req(0, 1'b1, 8'h09, 32'h90);
    run_transfer(1, 0, 1, g, lat);

    // Reset in the middle of a page-in, then a full restart.
    @(negedge clock);
    wait_cfg = 0;
    set_req(1, 1'b0, 8'h0C, 32'hC0);
    cyc = 0;
    while (!(busy && core_offset == 4'd7) && cyc < 200) begin
      @(negedge clock);
      cyc++;
    end
    check("reach_offset7", 300'(core_offset), 300'(7));
    reset = 1'b1;
    #1;
    check("midreset_mem",  300'({mem_req, mem_we, mem_addr, mem_wdata}), 300'(0));
    check("midreset_core", 300'({core_local_page, core_offset, core_data, core_write_page_in}), 300'(0));
    check("midreset_ctrl", 300'({busy, grant_id, out_accepted, in_done}), 300'(0));
    @(negedge clock);
    check("midreset_no_done", 300'({out_accepted, in_done}), 300'(0));
    mem_q.delete();
    wr_q.delete();
    model_rr = 0;
    reset = 1'b0;
    run_transfer(1, 0, 0, g, lat);

    // Randomized rounds of simultaneous requests.
    for (int r = 0; r < 20; r++) begin
      logic [N-1:0] o, n;
      @(negedge clock);
      wait_cfg = $urandom_range(0, 3);
      o = N'($urandom_range(0, 3));
      n = N'($urandom_range(0, 3));
      if (o == 0 && n == 0) o = 1;
      total = 0;
      for (int c = 0; c < N; c++) begin
        if (o[c]) begin set_req(c, 1'b1, 8'($urandom), $urandom); total++; end
        if (n[c]) begin set_req(c, 1'b0, 8'($urandom), $urandom); total++; end
      end
      for (int k = 0; k < total; k++) run_transfer(k == 0 ? 1 : 0, 0, 0, g, lat);
      check("round_drained", 300'({out_ready, in_request}), 300'(0));
    end

    repeat (3) @(negedge clock);
    check("final_idle", 300'({busy, mem_req}), 300'(0));
    finish_sim();
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    n_checks++;
    finish_sim();
  end

endmodule
